load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be none; widths come from the shared constants CPU_ADDR_WIDTH=32 and CPU_DATA_WIDTH=32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 lsu_addr  in  32  byte address from the memory stage.
REQ-005 lsu_wdata  in  32  store data, right-aligned.
REQ-006 lsu_cmd  in  2  IDLE=00, BYTE=01, HWORD=10, WORD=11; one-cycle pulse per access.
REQ-007 lsu_rnw  in  1  1=load, 0=store; valid with lsu_cmd.
REQ-008 lsu_rdata  out  32  load data, right-aligned, upper bits zero.
REQ-009 lsu_busy  out  1  stall request to the core.
REQ-010 lsu_err_align  out  1  one-cycle misalignment pulse.
REQ-011 lsu_err_bus  out  1  one-cycle bus-error pulse.
REQ-012 bus_addr  out  32  word-aligned address {addr[31:2],00}.
REQ-013 bus_cmd  out  2  IDLE=00, WRITE=01, READ=10.
REQ-014 bus_wdata  out  32  lane-replicated store data.
REQ-015 bus_be  out  4  byte enables; bit k selects data[8k+7:8k].
REQ-016 bus_cmd_accept  in  1  slave accepts bus_cmd this cycle.
REQ-017 bus_rdata  in  32  read data, valid with bus_resp=DVA.
REQ-018 bus_resp  in  2  NULL=00, DVA=01, ERR=11.

Function
REQ-019 The FSM SHALL have states IDLE, CMD and RESP.
REQ-020 In IDLE, an aligned lsu_cmd!=IDLE SHALL latch addr, wdata, size and rnw, then go to CMD.
REQ-021 Alignment error: HWORD with addr[0]=1, or WORD with addr[1:0]!=0; the FSM SHALL stay IDLE, issue no bus command, and pulse lsu_err_align in the next cycle.
REQ-022 lsu_busy SHALL be combinational: (lsu_cmd!=IDLE in IDLE) OR state!=IDLE.
REQ-023 In CMD, bus_cmd SHALL be READ or WRITE from registers; it SHALL be held stable until bus_cmd_accept=1, then the FSM goes to RESP. bus_cmd SHALL be IDLE in all other states.
REQ-024 In RESP, bus_resp=DVA SHALL return the FSM to IDLE; for a load, lsu_rdata SHALL be registered in the same edge.
REQ-025 In RESP, bus_resp=ERR SHALL return the FSM to IDLE, pulse lsu_err_bus in the next cycle, and leave lsu_rdata unchanged.
REQ-026 Stores SHALL also wait for DVA/ERR in RESP.
REQ-027 Best-case latency: command at cycle 0, bus_cmd at cycle 1 (accepted), response at cycle 2, lsu_busy low and lsu_rdata valid at cycle 3.
REQ-028 lsu_rdata SHALL hold its value until the next successful load completes.
REQ-029 Byte write lane steering: wdata[7:0] replicated to all four lanes, bus_be=0001<<addr[1:0].
REQ-030 Halfword write lane steering: wdata[15:0] replicated to both halves, bus_be=0011 if addr[1]=0, else 1100.
REQ-031 Word write lane steering: bus_be=1111.
REQ-032 Reads SHALL use bus_be as for writes, and bus_wdata SHALL be don't-care.
REQ-033 Load extraction: lsu_rdata = bus_rdata >> (8*addr[1:0]), masked to access size, zero-extended.
REQ-034 lsu_cmd seen outside IDLE SHALL be ignored, since the core is stalled then.
REQ-035 bus_resp!=NULL outside RESP SHALL be ignored.

Reset
REQ-036 While rst=1: state=IDLE, bus_cmd=IDLE, bus_addr=0, bus_wdata=0, bus_be=0, lsu_rdata=0, both error pulses=0; lsu_busy follows REQ-022, i.e. 0 with lsu_cmd=IDLE.
REQ-037 rst asserted mid-transaction SHALL abandon the access immediately, with no error pulse after release.

Structure
REQ-038 The LSU and bus command/response encodings SHALL live in the shared constants include (cpu_const.vh) alongside the existing CPU_LSU_* codes.
REQ-039 Lane steering and extraction SHALL be one combinational sub-module, lsu_lane_steer, instantiated once; the FSM stays in load_store_unit.

Verification
REQ-040 Aligned WORD load at 0x100 with bus_rdata=0xDEADBEEF, accept and DVA immediate -> bus_cmd=READ at cycle 1, bus_addr=0x100, bus_be=1111, lsu_busy cycles 0-2, lsu_rdata=0xDEADBEEF at cycle 3.
REQ-041 BYTE store of 0x5A at 0x203 -> bus_cmd=WRITE, bus_addr=0x200, bus_be=1000, bus_wdata=0x5A5A5A5A.
REQ-042 HWORD load at 0x102 with bus_rdata=0x8001FFFF -> lsu_rdata=0x00008001.
REQ-043 WORD load at 0x101 -> no bus_cmd ever, lsu_err_align=1 for exactly cycle 1, lsu_busy only at cycle 0.
REQ-044 Bus command held 3 cycles without accept, then bus_resp=ERR -> bus_cmd/bus_addr stable throughout, lsu_err_bus single pulse, lsu_rdata unchanged.
REQ-045 rst pulsed while in RESP -> bus_cmd=IDLE, lsu_busy=0, lsu_rdata=0 immediately; the next aligned load completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared CPU widths, LSU/bus encodings and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam int CPU_ADDR_WIDTH = 32;
  localparam int CPU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_BYTE  = 2'b01,
    LSU_HWORD = 2'b10,
    LSU_WORD  = 2'b11
  } lsu_cmd_e;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_WRITE = 2'b01,
    BUS_READ  = 2'b10
  } bus_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'b00,
    RESP_DVA  = 2'b01,
    RESP_ERR  = 2'b11
  } bus_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      LSU_HWORD: return addr_lo[0];
      LSU_WORD:  return (addr_lo != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_steer
// Description : Byte-lane steering for stores and zero-extending load extract.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_steer
  import load_store_unit_pkg::*;
(
  input  logic [1:0]                i_size,
  input  logic [1:0]                i_addr_lo,
  input  logic [CPU_DATA_WIDTH-1:0] i_wdata,
  input  logic [CPU_DATA_WIDTH-1:0] i_rdata,
  output logic [3:0]                o_be,
  output logic [CPU_DATA_WIDTH-1:0] o_wdata,
  output logic [CPU_DATA_WIDTH-1:0] o_rdata
);

  localparam logic [CPU_DATA_WIDTH-1:0] C_MASK_BYTE  = 32'h0000_00FF;
  localparam logic [CPU_DATA_WIDTH-1:0] C_MASK_HWORD = 32'h0000_FFFF;
  localparam logic [CPU_DATA_WIDTH-1:0] C_MASK_WORD  = 32'hFFFF_FFFF;

  logic [CPU_DATA_WIDTH-1:0] w_mask;
  logic [CPU_DATA_WIDTH-1:0] w_shifted;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    w_mask  = '0;
    case (i_size)
      LSU_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        w_mask  = C_MASK_BYTE;
      end
      LSU_HWORD: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        w_mask  = C_MASK_HWORD;
      end
      LSU_WORD: begin
        o_be    = 4'b1111;
        w_mask  = C_MASK_WORD;
      end
      default: ;
    endcase
  end

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign o_rdata   = w_shifted & w_mask;

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging the core to a
//               word-addressed command/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CPU_ADDR_WIDTH-1:0] lsu_addr,
  input  logic [CPU_DATA_WIDTH-1:0] lsu_wdata,
  input  logic [1:0]                lsu_cmd,
  input  logic                      lsu_rnw,
  output logic [CPU_DATA_WIDTH-1:0] lsu_rdata,
  output logic                      lsu_busy,
  output logic                      lsu_err_align,
  output logic                      lsu_err_bus,
  output logic [CPU_ADDR_WIDTH-1:0] bus_addr,
  output logic [1:0]                bus_cmd,
  output logic [CPU_DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]                bus_be,
  input  logic                      bus_cmd_accept,
  input  logic [CPU_DATA_WIDTH-1:0] bus_rdata,
  input  logic [1:0]                bus_resp
);

  lsu_state_e                r_state;
  lsu_state_e                w_next_state;
  logic [CPU_ADDR_WIDTH-1:0] r_addr;
  logic [CPU_DATA_WIDTH-1:0] r_wdata;
  logic [1:0]                r_size;
  logic                      r_rnw;
  logic [CPU_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err_align;
  logic                      r_err_bus;
  logic                      w_start;
  logic                      w_misalign;
  logic                      w_load_done;
  logic                      w_bus_err;
  logic [CPU_DATA_WIDTH-1:0] w_ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    bus_cmd      = BUS_IDLE;
    lsu_busy     = 1'b1;
    w_start      = 1'b0;
    w_misalign   = 1'b0;
    w_load_done  = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        lsu_busy = (lsu_cmd != LSU_IDLE);
        if (lsu_cmd != LSU_IDLE) begin
          if (is_misaligned(lsu_cmd, lsu_addr[1:0])) begin
            w_misalign = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_next_state = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        bus_cmd = r_rnw ? BUS_READ : BUS_WRITE;
        if (bus_cmd_accept) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        // NULL keeps waiting; stores complete on DVA just like loads.
        if (bus_resp == RESP_DVA) begin
          w_load_done  = r_rnw;
          w_next_state = ST_IDLE;
        end else if (bus_resp == RESP_ERR) begin
          w_bus_err    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        lsu_busy     = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= LSU_IDLE;
      r_rnw       <= 1'b0;
      r_rdata     <= '0;
      r_err_align <= 1'b0;
      r_err_bus   <= 1'b0;
    end else begin
      r_err_align <= w_misalign;
      r_err_bus   <= w_bus_err;
      if (w_start) begin
        r_addr  <= lsu_addr;
        r_wdata <= lsu_wdata;
        r_size  <= lsu_cmd;
        r_rnw   <= lsu_rnw;
      end
      if (w_load_done) r_rdata <= w_ld_data;
    end
  end

  // Bus-side byte enables/data and load extraction all derive from latched state.
  lsu_lane_steer u_lane_steer (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (bus_rdata),
    .o_be      (bus_be),
    .o_wdata   (bus_wdata),
    .o_rdata   (w_ld_data)
  );

  assign bus_addr      = {r_addr[CPU_ADDR_WIDTH-1:2], 2'b00};
  assign lsu_rdata     = r_rdata;
  assign lsu_err_align = r_err_align;
  assign lsu_err_bus   = r_err_bus;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed vector bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  lsu_cmd;
  logic        lsu_rnw, lsu_busy, lsu_err_align, lsu_err_bus;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_cmd, bus_resp;
  logic [3:0]  bus_be;
  logic        bus_cmd_accept;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_cmd        (lsu_cmd),
    .lsu_rnw        (lsu_rnw),
    .lsu_rdata      (lsu_rdata),
    .lsu_busy       (lsu_busy),
    .lsu_err_align  (lsu_err_align),
    .lsu_err_bus    (lsu_err_bus),
    .bus_addr       (bus_addr),
    .bus_cmd        (bus_cmd),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_cmd_accept (bus_cmd_accept),
    .bus_rdata      (bus_rdata),
    .bus_resp       (bus_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cmd;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    logic [1:0]  exp_bcmd;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic        chk_wd;
    logic [31:0] exp_bwd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Best-case access: accept and DVA given as early as possible.
  task automatic run_vector(input vec_t v, input int idx);
    next_cycle();
    lsu_cmd = v.cmd; lsu_rnw = v.rnw; lsu_addr = v.addr; lsu_wdata = v.wdata;
    bus_cmd_accept = 1'b1; bus_resp = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d c0 busy", idx), {31'd0, lsu_busy}, 32'd1);
    next_cycle();
    lsu_cmd = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d bus_cmd", idx), {30'd0, bus_cmd}, {30'd0, v.exp_bcmd});
    check($sformatf("v%0d bus_addr", idx), bus_addr, v.exp_baddr);
    check($sformatf("v%0d bus_be", idx), {28'd0, bus_be}, {28'd0, v.exp_be});
    if (v.chk_wd) check($sformatf("v%0d bus_wdata", idx), bus_wdata, v.exp_bwd);
    next_cycle();
    bus_resp = 2'b01; bus_rdata = v.bus_rd;
    @(negedge clk);
    check($sformatf("v%0d c2 busy", idx), {31'd0, lsu_busy}, 32'd1);
    check($sformatf("v%0d c2 bus_cmd", idx), {30'd0, bus_cmd}, 32'd0);
    next_cycle();
    bus_resp = 2'b00; bus_rdata = 32'h5A5A_A5A5;
    @(negedge clk);
    check($sformatf("v%0d c3 busy", idx), {31'd0, lsu_busy}, 32'd0);
    check($sformatf("v%0d lsu_rdata", idx), lsu_rdata, v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         cmd    rnw addr          wdata         bus_rd        bcmd  baddr         be       chk bwd           rd
    vecs[0] = '{2'b11, 1'b1, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2'b10, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF};
    vecs[1] = '{2'b01, 1'b0, 32'h0000_0203, 32'h1234_565A, 32'h0,        2'b01, 32'h0000_0200, 4'b1000, 1'b1, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
    vecs[2] = '{2'b10, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_FFFF, 2'b10, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        32'h0000_8001};
    vecs[3] = '{2'b01, 1'b1, 32'h0000_0301, 32'h0,        32'h1122_3344, 2'b10, 32'h0000_0300, 4'b0010, 1'b0, 32'h0,        32'h0000_0033};
    vecs[4] = '{2'b10, 1'b0, 32'h0000_0400, 32'hFFFF_ABCD, 32'h0,        2'b01, 32'h0000_0400, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h0000_0033};
    vecs[5] = '{2'b01, 1'b1, 32'h0000_0502, 32'h0,        32'hCAFE_F00D, 2'b10, 32'h0000_0500, 4'b0100, 1'b0, 32'h0,        32'h0000_00FE};
    vecs[6] = '{2'b10, 1'b1, 32'h0000_0600, 32'h0,        32'h8001_FFFF, 2'b10, 32'h0000_0600, 4'b0011, 1'b0, 32'h0,        32'h0000_FFFF};
    vecs[7] = '{2'b01, 1'b0, 32'h0000_0200, 32'h0000_00C3, 32'h0,        2'b01, 32'h0000_0200, 4'b0001, 1'b1, 32'hC3C3_C3C3, 32'h0000_FFFF};
    vecs[8] = '{2'b11, 1'b0, 32'h0000_07FC, 32'h1234_5678, 32'h0,        2'b01, 32'h0000_07FC, 4'b1111, 1'b1, 32'h1234_5678, 32'h0000_FFFF};
    vecs[9] = '{2'b01, 1'b1, 32'h0000_0000, 32'h0,        32'h1122_3344, 2'b10, 32'h0000_0000, 4'b0001, 1'b0, 32'h0,        32'h0000_0044};

    rst = 1'b1; lsu_addr = '0; lsu_wdata = '0; lsu_cmd = 2'b00; lsu_rnw = 1'b0;
    bus_cmd_accept = 1'b0; bus_rdata = '0; bus_resp = 2'b00;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst bus_cmd",   {30'd0, bus_cmd}, 32'd0);
    check("rst bus_addr",  bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst bus_be",    {28'd0, bus_be}, 32'd0);
    check("rst lsu_rdata", lsu_rdata, 32'd0);
    check("rst err_align", {31'd0, lsu_err_align}, 32'd0);
    check("rst err_bus",   {31'd0, lsu_err_bus}, 32'd0);
    check("rst busy",      {31'd0, lsu_busy}, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vector(vecs[i], i);

    // Misaligned WORD at 0x101 and HWORD at 0x103.
    for (int m = 0; m < 2; m++) begin
      next_cycle();
      lsu_cmd = (m == 0) ? 2'b11 : 2'b10; lsu_rnw = 1'b1;
      lsu_addr = (m == 0) ? 32'h0000_0101 : 32'h0000_0103;
      bus_cmd_accept = 1'b1;
      @(negedge clk);
      check($sformatf("mis%0d c0 busy", m), {31'd0, lsu_busy}, 32'd1);
      check($sformatf("mis%0d c0 bus_cmd", m), {30'd0, bus_cmd}, 32'd0);
      next_cycle();
      lsu_cmd = 2'b00;
      @(negedge clk);
      check($sformatf("mis%0d c1 err_align", m), {31'd0, lsu_err_align}, 32'd1);
      check($sformatf("mis%0d c1 busy", m), {31'd0, lsu_busy}, 32'd0);
      check($sformatf("mis%0d c1 bus_cmd", m), {30'd0, bus_cmd}, 32'd0);
      check($sformatf("mis%0d c1 err_bus", m), {31'd0, lsu_err_bus}, 32'd0);
      next_cycle();
      @(negedge clk);
      check($sformatf("mis%0d c2 err_align", m), {31'd0, lsu_err_align}, 32'd0);
      check($sformatf("mis%0d c2 bus_cmd", m), {30'd0, bus_cmd}, 32'd0);
    end

    // HWORD load held three cycles before accept, then ERR response.
    next_cycle();
    lsu_cmd = 2'b10; lsu_rnw = 1'b1; lsu_addr = 32'h0000_0202;
    bus_cmd_accept = 1'b0; bus_resp = 2'b00;
    @(negedge clk);
    check("err c0 busy", {31'd0, lsu_busy}, 32'd1);
    next_cycle();
    lsu_cmd = 2'b00; bus_resp = 2'b01; bus_rdata = 32'h9999_9999;
    @(negedge clk);
    check("err c1 bus_cmd", {30'd0, bus_cmd}, 32'd2);
    check("err c1 bus_addr", bus_addr, 32'h0000_0200);
    next_cycle();
    bus_resp = 2'b00; lsu_cmd = 2'b11; lsu_rnw = 1'b0; lsu_addr = 32'h0000_0900;
    @(negedge clk);
    check("err c2 bus_cmd", {30'd0, bus_cmd}, 32'd2);
    check("err c2 bus_addr", bus_addr, 32'h0000_0200);
    check("err c2 bus_be", {28'd0, bus_be}, 32'hC);
    next_cycle();
    lsu_cmd = 2'b00; bus_cmd_accept = 1'b1;
    @(negedge clk);
    check("err c3 bus_cmd", {30'd0, bus_cmd}, 32'd2);
    check("err c3 bus_addr", bus_addr, 32'h0000_0200);
    next_cycle();
    bus_cmd_accept = 1'b0; bus_resp = 2'b11; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check("err c4 bus_cmd", {30'd0, bus_cmd}, 32'd0);
    check("err c4 busy", {31'd0, lsu_busy}, 32'd1);
    check("err c4 err_bus", {31'd0, lsu_err_bus}, 32'd0);
    next_cycle();
    bus_resp = 2'b00;
    @(negedge clk);
    check("err c5 err_bus", {31'd0, lsu_err_bus}, 32'd1);
    check("err c5 busy", {31'd0, lsu_busy}, 32'd0);
    check("err c5 lsu_rdata", lsu_rdata, 32'h0000_0044);
    check("err c5 err_align", {31'd0, lsu_err_align}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("err c6 err_bus", {31'd0, lsu_err_bus}, 32'd0);
    check("err c6 bus_cmd", {30'd0, bus_cmd}, 32'd0);

    // Reset while waiting in RESP, then a normal load.
    next_cycle();
    lsu_cmd = 2'b11; lsu_rnw = 1'b1; lsu_addr = 32'h0000_0800; bus_cmd_accept = 1'b1;
    @(negedge clk);
    check("rstx c0 busy", {31'd0, lsu_busy}, 32'd1);
    next_cycle();
    lsu_cmd = 2'b00;
    @(negedge clk);
    check("rstx c1 bus_cmd", {30'd0, bus_cmd}, 32'd2);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstx bus_cmd", {30'd0, bus_cmd}, 32'd0);
    check("rstx busy", {31'd0, lsu_busy}, 32'd0);
    check("rstx lsu_rdata", lsu_rdata, 32'd0);
    check("rstx bus_be", {28'd0, bus_be}, 32'd0);
    next_cycle();
    rst = 1'b0; bus_resp = 2'b11;
    @(negedge clk);
    check("rstx post busy", {31'd0, lsu_busy}, 32'd0);
    check("rstx post bus_cmd", {30'd0, bus_cmd}, 32'd0);
    next_cycle();
    bus_resp = 2'b00;
    @(negedge clk);
    check("rstx post err_bus", {31'd0, lsu_err_bus}, 32'd0);
    check("rstx post err_align", {31'd0, lsu_err_align}, 32'd0);
    run_vector('{2'b11, 1'b1, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 2'b10, 32'h0000_0104,
                 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D}, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
